// File: rtl/rx_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_pkg
//  Description : Shared constants for the RX frame parser: sync bytes,
//                FSM state encoding, error codes and a length helper.
//                Optional feature macro: RX_FRAME_CHECKSUM_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package rx_frame_pkg;

    // Frame delimiters: every frame starts with SYNC1 followed by SYNC2
    localparam logic [7:0] c_SYNC1_BYTE = 8'h55;
    localparam logic [7:0] c_SYNC2_BYTE = 8'hAA;

    // Parser state encoding
    localparam int unsigned c_STATE_W = 3;
    typedef logic [c_STATE_W-1:0] state_t;

    localparam state_t c_HUNT_SYNC1  = 3'd0;
    localparam state_t c_HUNT_SYNC2  = 3'd1;
    localparam state_t c_GET_LEN     = 3'd2;
    localparam state_t c_GET_PAYLOAD = 3'd3;
    localparam state_t c_GET_CSUM    = 3'd4;

    // err_code values reported alongside frame_err
    localparam logic [1:0] c_ERR_BAD_LEN  = 2'd0;
    localparam logic [1:0] c_ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] c_ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd3;

    // A LEN byte is usable when it names at least one and at most max_len bytes
    function automatic logic len_in_range(input logic [7:0] len, input int unsigned max_len);
        return (len != 8'd0) && (32'(len) <= max_len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : rx_timeout_counter
//  Description : Inter-byte idle counter. Counts enabled cycles since the
//                last restart; 'expired' is high in the TIMEOUT_CYCLES-th
//                consecutive idle cycle and stays high until restarted.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Idle cycle counter: cleared by a byte or while disabled, saturates at the last value
    always_ff @(posedge clk) begin
        if (rst || restart || !enable) begin
            r_cnt <= '0;
        end else if (r_cnt != c_LAST) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign expired = enable && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/rx_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_parser
//  Description : Byte-stream frame parser for frames of the form
//                55 AA LEN payload[LEN] (CSUM). Payload bytes are streamed
//                to a FIFO; completion and aborts are reported by pulses.
//                Optional feature macro: RX_FRAME_CHECKSUM_EN (adds the CSUM
//                byte and the running-sum check).
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_parser #(
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done_signal,
    input  logic       fifo_full,
    output logic       fifo_wr_en,
    output logic [7:0] fifo_wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] frame_len,
    output logic       busy
);

    import rx_frame_pkg::*;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_len;
    logic [7:0] r_cnt;
    logic       w_expired;
    logic       w_len_ok;
    logic       w_last;

    logic       w_wr_en;
    logic       w_done;
    logic       w_err;
    logic [1:0] w_err_code;

    logic       r_wr_en;
    logic [7:0] r_wr_data;
    logic       r_done;
    logic       r_err;
    logic [1:0] r_err_code;
    logic [7:0] r_frame_len;

`ifdef RX_FRAME_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_csum_ok;
    assign w_csum_ok = (rx_data == r_sum);
`endif

    assign busy     = (r_state != c_HUNT_SYNC1);
    assign w_len_ok = len_in_range(rx_data, MAX_LEN);
    assign w_last   = (r_cnt == (r_len - 8'd1));

    rx_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_done_signal),
        .enable  (busy),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_HUNT_SYNC1;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; an arriving byte always wins over a timeout in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (rx_done_signal) begin
            case (r_state)
                c_HUNT_SYNC1: begin
                    if (rx_data == c_SYNC1_BYTE) w_state_nxt = c_HUNT_SYNC2;
                end
                c_HUNT_SYNC2: begin
                    if (rx_data == c_SYNC2_BYTE)      w_state_nxt = c_GET_LEN;
                    else if (rx_data != c_SYNC1_BYTE) w_state_nxt = c_HUNT_SYNC1;
                end
                c_GET_LEN: begin
                    w_state_nxt = w_len_ok ? c_GET_PAYLOAD : c_HUNT_SYNC1;
                end
                c_GET_PAYLOAD: begin
                    if (fifo_full) begin
                        w_state_nxt = c_HUNT_SYNC1;
                    end else if (w_last) begin
`ifdef RX_FRAME_CHECKSUM_EN
                        w_state_nxt = c_GET_CSUM;
`else
                        w_state_nxt = c_HUNT_SYNC1;
`endif
                    end
                end
`ifdef RX_FRAME_CHECKSUM_EN
                c_GET_CSUM: begin
                    w_state_nxt = c_HUNT_SYNC1;
                end
`endif
                default: begin
                    w_state_nxt = c_HUNT_SYNC1;
                end
            endcase
        end else if (w_expired) begin
            w_state_nxt = c_HUNT_SYNC1;
        end
    end

    // Output decode: payload write, accept and abort decisions for this cycle
    always_comb begin
        w_wr_en    = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_err_code = c_ERR_BAD_LEN;
        if (rx_done_signal) begin
            case (r_state)
                c_GET_LEN: begin
                    if (!w_len_ok) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_BAD_LEN;
                    end
                end
                c_GET_PAYLOAD: begin
                    if (fifo_full) begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_OVERFLOW;
                    end else begin
                        w_wr_en = 1'b1;
`ifndef RX_FRAME_CHECKSUM_EN
                        w_done  = w_last;
`endif
                    end
                end
`ifdef RX_FRAME_CHECKSUM_EN
                c_GET_CSUM: begin
                    if (w_csum_ok) begin
                        w_done = 1'b1;
                    end else begin
                        w_err      = 1'b1;
                        w_err_code = c_ERR_CHECKSUM;
                    end
                end
`endif
                default: begin
                end
            endcase
        end else if (w_expired) begin
            w_err      = 1'b1;
            w_err_code = c_ERR_TIMEOUT;
        end
    end

    // Registered outputs: pulses appear one cycle after the triggering event
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en     <= 1'b0;
            r_wr_data   <= 8'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= c_ERR_BAD_LEN;
            r_frame_len <= 8'd0;
        end else begin
            r_wr_en <= w_wr_en;
            r_done  <= w_done;
            r_err   <= w_err;
            if (w_wr_en) r_wr_data   <= rx_data;
            if (w_err)   r_err_code  <= w_err_code;
            if (w_done)  r_frame_len <= r_len;
        end
    end

    // Frame datapath: latched length, payload byte counter and running sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len <= 8'd0;
            r_cnt <= 8'd0;
`ifdef RX_FRAME_CHECKSUM_EN
            r_sum <= 8'd0;
`endif
        end else if (rx_done_signal) begin
            if (r_state == c_GET_LEN && w_len_ok) begin
                r_len <= rx_data;
                r_cnt <= 8'd0;
`ifdef RX_FRAME_CHECKSUM_EN
                r_sum <= rx_data;
`endif
            end else if (r_state == c_GET_PAYLOAD && !fifo_full) begin
                r_cnt <= r_cnt + 8'd1;
`ifdef RX_FRAME_CHECKSUM_EN
                r_sum <= r_sum + rx_data;
`endif
            end
        end
    end

    assign fifo_wr_en   = r_wr_en;
    assign fifo_wr_data = r_wr_data;
    assign frame_done   = r_done;
    assign frame_err    = r_err;
    assign err_code     = r_err_code;
    assign frame_len    = r_frame_len;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_frame_parser
//  Description : Self-checking bench for rx_frame_parser. Directed frames and
//                random byte streams are scored against a stream-parsing
//                reference model, cycle-exact. Honours RX_FRAME_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_parser;

    localparam int c_MAX_LEN = 8;
    localparam int c_TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done_signal;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_len;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Stimulus record: byte, fifo_full flag and the cycle it was presented
    logic [7:0]  stim_b[$];
    bit          stim_f[$];
    int          stim_c[$];
    // Observed and expected writes / events. Event = {is_err, code, len}
    logic [7:0]  got_wr[$];
    int          got_wr_c[$];
    logic [10:0] got_ev[$];
    int          got_ev_c[$];
    logic [7:0]  exp_wr[$];
    int          exp_wr_c[$];
    logic [10:0] exp_ev[$];
    int          exp_ev_c[$];
    logic [7:0]  dir_q[$];

    rx_frame_parser #(
        .MAX_LEN        (c_MAX_LEN),
        .TIMEOUT_CYCLES (c_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_data        (rx_data),
        .rx_done_signal (rx_done_signal),
        .fifo_full      (fifo_full),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_wr_data   (fifo_wr_data),
        .frame_done     (frame_done),
        .frame_err      (frame_err),
        .err_code       (err_code),
        .frame_len      (frame_len),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge
    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            got_wr.push_back(fifo_wr_data);
            got_wr_c.push_back(cyc);
        end
        if (frame_done === 1'b1) begin
            got_ev.push_back({1'b0, 2'b00, frame_len});
            got_ev_c.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            got_ev.push_back({1'b1, err_code, 8'h00});
            got_ev_c.push_back(cyc);
        end
        if (frame_done === 1'b1 || frame_err === 1'b1) begin
            n_checks++;
            assert (!(frame_done === 1'b1 && frame_err === 1'b1)) else begin
                n_errors++;
                $error("FAIL done_and_err: observed both high at cycle %0d, required exclusive", cyc);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte for one cycle; returns 1ns after the edge that sampled it
    task automatic send(input logic [7:0] b, input bit full);
        stim_b.push_back(b);
        stim_f.push_back(full);
        stim_c.push_back(cyc);
        rx_data        = b;
        fifo_full      = full;
        rx_done_signal = 1'b1;
        @(posedge clk);
        #1;
        rx_done_signal = 1'b0;
        fifo_full      = 1'b0;
        rx_data        = 8'($urandom);
    endtask

    task automatic send_dir();
        foreach (dir_q[k]) send(dir_q[k], 1'b0);
    endtask

    task automatic clear_all();
        stim_b.delete(); stim_f.delete(); stim_c.delete();
        got_wr.delete(); got_wr_c.delete(); got_ev.delete(); got_ev_c.delete();
        exp_wr.delete(); exp_wr_c.delete(); exp_ev.delete(); exp_ev_c.delete();
    endtask

    task automatic push_ev(input logic [10:0] e, input int c);
        exp_ev.push_back(e);
        exp_ev_c.push_back(c);
    endtask

    // 0: byte i is available in time, 1: stream ended, 2: idle gap before it exceeded the timeout
    function automatic int gap_state(input int i);
        if (i >= stim_b.size()) return 1;
        if (i > 0 && (stim_c[i] - stim_c[i-1]) > c_TIMEOUT) return 2;
        return 0;
    endfunction

    // Parse one frame whose first 55 is at s-1. nx = next index to scan, -1 if stream ended mid-frame
    task automatic parse_frame(input int s, output int nx);
        int         i;
        int         len;
        int         st;
        logic [7:0] sum;
        i  = s;
        nx = -1;
        forever begin
            st = gap_state(i);
            if (st == 1) return;
            if (st == 2) begin push_ev({1'b1, 2'd3, 8'h00}, stim_c[i-1] + c_TIMEOUT + 1); nx = i; return; end
            if (stim_b[i] != 8'h55) break;
            i++;
        end
        if (stim_b[i] != 8'hAA) begin nx = i + 1; return; end
        i++;
        st = gap_state(i);
        if (st == 1) return;
        if (st == 2) begin push_ev({1'b1, 2'd3, 8'h00}, stim_c[i-1] + c_TIMEOUT + 1); nx = i; return; end
        len = int'(stim_b[i]);
        if (len == 0 || len > c_MAX_LEN) begin
            push_ev({1'b1, 2'd0, 8'h00}, stim_c[i] + 1);
            nx = i + 1;
            return;
        end
        sum = 8'(len);
        i++;
        for (int k = 0; k < len; k++) begin
            st = gap_state(i);
            if (st == 1) return;
            if (st == 2) begin push_ev({1'b1, 2'd3, 8'h00}, stim_c[i-1] + c_TIMEOUT + 1); nx = i; return; end
            if (stim_f[i]) begin
                push_ev({1'b1, 2'd2, 8'h00}, stim_c[i] + 1);
                nx = i + 1;
                return;
            end
            exp_wr.push_back(stim_b[i]);
            exp_wr_c.push_back(stim_c[i] + 1);
            sum = sum + stim_b[i];
            i++;
        end
`ifdef RX_FRAME_CHECKSUM_EN
        st = gap_state(i);
        if (st == 1) return;
        if (st == 2) begin push_ev({1'b1, 2'd3, 8'h00}, stim_c[i-1] + c_TIMEOUT + 1); nx = i; return; end
        if (stim_b[i] == sum) push_ev({1'b0, 2'd0, 8'(len)}, stim_c[i] + 1);
        else                  push_ev({1'b1, 2'd1, 8'h00}, stim_c[i] + 1);
        nx = i + 1;
`else
        push_ev({1'b0, 2'd0, 8'(len)}, stim_c[i-1] + 1);
        nx = i;
`endif
    endtask

    // Reference model over the whole recorded stream
    task automatic model();
        int i;
        int nx;
        i = 0;
        while (i < stim_b.size()) begin
            if (stim_b[i] != 8'h55) begin
                i++;
            end else begin
                parse_frame(i + 1, nx);
                if (nx < 0) begin
                    push_ev({1'b1, 2'd3, 8'h00}, stim_c[stim_c.size()-1] + c_TIMEOUT + 1);
                    break;
                end
                i = nx;
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, " wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++) begin
            chk({tag, " wr_data"}, 32'(got_wr[k]), 32'(exp_wr[k]));
            chk({tag, " wr_cycle"}, 32'(got_wr_c[k]), 32'(exp_wr_c[k]));
        end
        chk({tag, " ev_count"}, 32'(got_ev.size()), 32'(exp_ev.size()));
        for (int k = 0; k < exp_ev.size() && k < got_ev.size(); k++) begin
            chk({tag, " ev_kind"}, 32'(got_ev[k]), 32'(exp_ev[k]));
            chk({tag, " ev_cycle"}, 32'(got_ev_c[k]), 32'(exp_ev_c[k]));
        end
        clear_all();
    endtask

    task automatic finish_seq(input string tag);
        idle(c_TIMEOUT + 4);
        model();
        compare(tag);
    endtask

    initial begin
        rst            = 1'b1;
        rx_data        = 8'h00;
        rx_done_signal = 1'b0;
        fifo_full      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset fifo_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("reset fifo_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset err_code", 32'(err_code), 32'd0);
        chk("reset frame_len", 32'(frame_len), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        clear_all();
        idle(2);

        // Good 3-byte frame; sum 03+11+22+33 = 69
        send(8'h55, 1'b0);
        chk("sync1 busy", 32'(busy), 32'd1);
        send(8'hAA, 1'b0);
        send(8'h03, 1'b0);
        send(8'h11, 1'b0);
        chk("first write strobe", 32'(fifo_wr_en), 32'd1);
        chk("first write data", 32'(fifo_wr_data), 32'h11);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
`ifdef RX_FRAME_CHECKSUM_EN
        chk("no done before csum", 32'(frame_done), 32'd0);
        send(8'h69, 1'b0);
`endif
        chk("good frame_done", 32'(frame_done), 32'd1);
        chk("good frame_len", 32'(frame_len), 32'd3);
`ifndef RX_FRAME_CHECKSUM_EN
        send(8'h69, 1'b0);
`endif
        idle(1);
        chk("idle after frame busy", 32'(busy), 32'd0);
        finish_seq("good3");

        // FIFO full on the second payload byte
        send(8'h55, 1'b0); send(8'hAA, 1'b0); send(8'h03, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        chk("overflow no write", 32'(fifo_wr_en), 32'd0);
        chk("overflow frame_err", 32'(frame_err), 32'd1);
        chk("overflow err_code", 32'(err_code), 32'd2);
        send(8'h33, 1'b0);
        finish_seq("overflow");

        // Zero length
        dir_q = '{8'h55, 8'hAA, 8'h00};
        send_dir();
        chk("len0 frame_err", 32'(frame_err), 32'd1);
        chk("len0 err_code", 32'(err_code), 32'd0);
        finish_seq("len0");

        // Length just above MAX_LEN
        dir_q = '{8'h55, 8'hAA, 8'h09};
        send_dir();
        chk("len9 frame_err", 32'(frame_err), 32'd1);
        finish_seq("len_over");

        // Length exactly MAX_LEN; sum 08+01..08 = 0x2C
        dir_q = '{8'h55, 8'hAA, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_dir();
`ifdef RX_FRAME_CHECKSUM_EN
        send(8'h2C, 1'b0);
`endif
        chk("maxlen frame_done", 32'(frame_done), 32'd1);
        chk("maxlen frame_len", 32'(frame_len), 32'd8);
        chk("err_code held", 32'(err_code), 32'd0);
        finish_seq("maxlen");

        // Repeated sync1 then a 1-byte frame; sum 01+7E = 7F
        dir_q = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
        send_dir();
        finish_seq("dup_sync");

`ifdef RX_FRAME_CHECKSUM_EN
        // Wrong checksum
        dir_q = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
        send_dir();
        chk("csum frame_err", 32'(frame_err), 32'd1);
        chk("csum err_code", 32'(err_code), 32'd1);
        finish_seq("bad_csum");
`endif

        // Silence after LEN: abort one cycle after expiry
        dir_q = '{8'h55, 8'hAA, 8'h03};
        send_dir();
        idle(c_TIMEOUT - 1);
        chk("pre-timeout frame_err", 32'(frame_err), 32'd0);
        idle(1);
        chk("timeout frame_err", 32'(frame_err), 32'd1);
        chk("timeout err_code", 32'(err_code), 32'd3);
        finish_seq("timeout");

        // Byte exactly at expiry takes priority; sum 02+11+22 = 35
        dir_q = '{8'h55, 8'hAA, 8'h02};
        send_dir();
        idle(c_TIMEOUT - 1);
        send(8'h11, 1'b0);
        chk("expiry byte no err", 32'(frame_err), 32'd0);
        chk("expiry byte written", 32'(fifo_wr_en), 32'd1);
        send(8'h22, 1'b0);
`ifdef RX_FRAME_CHECKSUM_EN
        send(8'h35, 1'b0);
`endif
        finish_seq("expiry_byte");

        // Reset in the middle of the payload
        dir_q = '{8'h55, 8'hAA, 8'h04, 8'h11, 8'h22};
        send_dir();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst fifo_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("midrst fifo_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("midrst frame_len", 32'(frame_len), 32'd0);
        chk("midrst err_code", 32'(err_code), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        idle(c_TIMEOUT + 4);
        chk("midrst no events", 32'(got_ev.size()), 32'd0);
        chk("midrst writes kept", 32'(got_wr.size()), 32'd2);
        clear_all();
        // Clean frame after reset; sum 02+A1+B3 = 56
        dir_q = '{8'h55, 8'hAA, 8'h02, 8'hA1, 8'hB3};
        send_dir();
`ifdef RX_FRAME_CHECKSUM_EN
        send(8'h56, 1'b0);
`endif
        chk("post-reset frame_done", 32'(frame_done), 32'd1);
        finish_seq("post_reset");

        // Random streams biased towards frame structure
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 40; b++) begin
                int         r;
                int         g;
                logic [7:0] v;
                r = int'($urandom_range(0, 99));
                if (r < 20)      v = 8'h55;
                else if (r < 35) v = 8'hAA;
                else if (r < 60) v = 8'($urandom_range(0, c_MAX_LEN + 1));
                else             v = 8'($urandom);
                r = int'($urandom_range(0, 99));
                if (r < 80)      g = 0;
                else if (r < 92) g = int'($urandom_range(1, 3));
                else if (r < 96) g = c_TIMEOUT - 1;
                else             g = c_TIMEOUT;
                idle(g);
                send(v, $urandom_range(0, 9) == 0);
            end
            finish_seq("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
